// File: rtl/eta1_err_monitor.sv
// Error-statistics monitor for the eta1 approximate adder: compares each approximate sum against
// the exact a+b and accumulates error count, saturating sum of |error| and max |error| over N beats.
module eta1_err_monitor #(
  parameter int BIT_WIDTH = 8,
  parameter int CNT_W     = 16,
  parameter int ACC_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic [BIT_WIDTH:0]   approx,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     err_count,
  output logic [ACC_W-1:0]     sum_abs_err,
  output logic [BIT_WIDTH:0]   max_abs_err
);

  // state    | meaning
  // ST_IDLE  | after reset, waiting for start
  // ST_RUN   | accepting beats until n_samples have been taken
  // ST_DRAIN | no new beats, letting the pipeline retire into the stats
  // ST_DONE  | results stable, waiting for start
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam int EW = BIT_WIDTH + 1;
  // Sum is formed one bit wider than the larger operand so the carry flags saturation.
  localparam int SW = ((ACC_W > EW) ? ACC_W : EW) + 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [EW-1:0]        s1_exact_q, s1_exact_d;
  logic [EW-1:0]        s1_approx_q, s1_approx_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [ACC_W-1:0]     sum_q, sum_d;
  logic [EW-1:0]        max_q, max_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic [EW-1:0]        abs_err;
  logic [SW-1:0]        sum_ext;
  logic [CNT_W-1:0]     acc_cnt_inc;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    acc_cnt_d   = acc_cnt_q;
    err_d       = err_q;
    sum_d       = sum_q;
    max_d       = max_q;

    accept      = in_valid & in_ready_q;
    acc_cnt_inc = acc_cnt_q + 1'b1;

    s1_valid_d  = accept;
    s1_exact_d  = accept ? ({1'b0, a} + {1'b0, b}) : s1_exact_q;
    s1_approx_d = accept ? approx : s1_approx_q;

    abs_err = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                          : (s1_approx_q - s1_exact_q);
    sum_ext = SW'(sum_q) + SW'(abs_err);

    if (s1_valid_q) begin
      err_d = err_q + CNT_W'(abs_err != '0);
      sum_d = (sum_ext > SW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      if (abs_err > max_q) max_d = abs_err;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_d     = '0;
          sum_d     = '0;
          max_d     = '0;
          acc_cnt_d = '0;
          n_d       = n_samples;
          state_d   = (n_samples != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_inc;
          if (acc_cnt_inc == n_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Only S1 holds pending work; S2 is the stats registers themselves.
        if (!s1_valid_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      acc_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      err_q       <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      acc_cnt_q   <= acc_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_exact_q  <= s1_exact_d;
      s1_approx_q <= s1_approx_d;
      err_q       <= err_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_count   = err_q;
  assign sum_abs_err = sum_q;
  assign max_abs_err = max_q;

endmodule

// File: tb/tb_eta1_err_monitor.sv
// Scoreboard bench for eta1_err_monitor: a default instance and an ACC_W=6 instance share stimulus;
// expected results are queued per run and checked when done rises.
module tb_eta1_err_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] n_samples;
  logic        in_valid;
  logic [7:0]  a, b;
  logic [8:0]  approx;

  logic        in_ready, busy, done;
  logic [15:0] err_count;
  logic [31:0] sum_abs_err;
  logic [8:0]  max_abs_err;

  logic        sat_in_ready, sat_busy, sat_done;
  logic [15:0] sat_err_count;
  logic [5:0]  sat_sum_abs_err;
  logic [8:0]  sat_max_abs_err;

  eta1_err_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx(approx),
    .busy(busy), .done(done), .err_count(err_count),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err)
  );

  eta1_err_monitor #(.ACC_W(6)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(sat_in_ready), .a(a), .b(b), .approx(approx),
    .busy(sat_busy), .done(sat_done), .err_count(sat_err_count),
    .sum_abs_err(sat_sum_abs_err), .max_abs_err(sat_max_abs_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int err;
    int sum;
    int sat_sum;
    int mx;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   hs_cnt = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic push_exp(input int e, input int s, input int ss, input int m);
    exp_t x;
    x.err = e; x.sum = s; x.sat_sum = ss; x.mx = m;
    sb.push_back(x);
  endtask

  // Scoreboard monitor: one expected record per completed run.
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected_done: got done with empty queue, expected none");
      end else begin
        e = sb.pop_front();
        chk("err_count",   err_count,       e.err);
        chk("sum_abs_err", sum_abs_err,     e.sum);
        chk("max_abs_err", max_abs_err,     e.mx);
        chk("sat_done",    sat_done,        1);
        chk("sat_sum",     sat_sum_abs_err, e.sat_sum);
        chk("sat_err",     sat_err_count,   e.err);
        chk("sat_max",     sat_max_abs_err, e.mx);
      end
    end
    done_prev = done;
  end

  always @(posedge clk) if (in_valid && in_ready) hs_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_run(input int n);
    start     = 1'b1;
    n_samples = 16'(n);
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [8:0] vap);
    int guard = 0;
    in_valid = 1'b1; a = va; b = vb; approx = vap;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("send_timeout", guard, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Last accept was at cycle t; we are in cycle t+1. done must rise in cycle t+3.
  task automatic finish_run(input string nm);
    chk({nm, "_ready_drain"}, in_ready, 0);
    chk({nm, "_busy_drain"},  busy,     1);
    @(negedge clk);
    chk({nm, "_done_t2"}, done, 0);
    @(negedge clk);
    chk({nm, "_done_t3"}, done, 1);
    chk({nm, "_busy_t3"}, busy, 0);
  endtask

  task automatic run_t1(input string nm);
    start_run(3);
    send(8'h1F, 8'h01, 9'h01F);
    send(8'h10, 8'h10, 9'h000);
    send(8'h20, 8'h20, 9'h040);
    finish_run(nm);
  endtask

  initial begin
    int hs_base;
    logic [7:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; n_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; approx = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy",     busy,     0);
    chk("rst_done",     done,     0);
    chk("rst_err",      err_count, 0);
    chk("rst_sum",      sum_abs_err, 0);
    chk("rst_max",      max_abs_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T4: zero-length run
    push_exp(0, 0, 0, 0);
    start_run(0);
    chk("t4_done_next", done, 1);
    chk("t4_ready", in_ready, 0);
    @(negedge clk);

    // T1
    push_exp(2, 33, 33, 32);
    run_t1("t1");
    @(negedge clk);

    // T6: start in RUN ignored, then rerun from DONE
    push_exp(2, 33, 33, 32);
    start_run(3);
    send(8'h1F, 8'h01, 9'h01F);
    start = 1'b1; n_samples = 16'd0;
    send(8'h10, 8'h10, 9'h000);
    start = 1'b0;
    chk("t6_busy_after_start", busy, 1);
    send(8'h20, 8'h20, 9'h040);
    finish_run("t6a");
    push_exp(2, 33, 33, 32);
    run_t1("t6b");
    @(negedge clk);

    // T3: abs_err 32 per beat; ACC_W=6 instance saturates at 63
    push_exp(3, 96, 63, 32);
    start_run(3);
    repeat (3) send(8'h10, 8'h10, 9'h000);
    finish_run("t3");
    @(negedge clk);

    // T2: exact adder, 1000 beats with gaps
    push_exp(0, 0, 0, 0);
    hs_base = hs_cnt;
    start_run(1000);
    for (int i = 0; i < 1000; i++) begin
      if (i != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      send(ra, rb, {1'b0, ra} + {1'b0, rb});
    end
    finish_run("t2");
    chk("t2_accepts", hs_cnt - hs_base, 1000);
    @(negedge clk);

    // T5: reset mid-run, then fresh run
    start_run(10);
    repeat (5) send(8'h10, 8'h10, 9'h000);
    chk("t5_partial_err", err_count, 4);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_err",   err_count, 0);
    chk("t5_rst_sum",   sum_abs_err, 0);
    chk("t5_rst_max",   max_abs_err, 0);
    chk("t5_rst_busy",  busy, 0);
    chk("t5_rst_ready", in_ready, 0);
    chk("t5_rst_done",  done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(2, 64, 63, 32);
    start_run(2);
    repeat (2) send(8'h10, 8'h10, 9'h000);
    finish_run("t5");
    repeat (2) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
